// File: rtl/seg_pkg.sv
// seg_pkg: shared types and helpers for the 7-segment scan controller.
//   SEG_BLANK  - segment pattern with every segment off (active-low)
//   state_t    - scan FSM states
//   lz_mask    - leading-zero blanking mask over up to MAX_DIGITS nibbles
package seg_pkg;

  localparam logic [6:0]  SEG_BLANK  = 7'h7F;
  localparam int unsigned MAX_DIGITS = 8;
  localparam int unsigned LZ_W       = 4 * MAX_DIGITS;
  localparam int unsigned MASK_IDX_W = $clog2(MAX_DIGITS);

  typedef enum logic {
    GUARD = 1'b0,
    DRIVE = 1'b1
  } state_t;

  // Bit i set when digit i is a leading zero among the lowest n digits.
  // Digit 0 is never marked, so an all-zero value still shows a single "0".
  function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [LZ_W-1:0] v,
                                                    input int unsigned    n);
    logic [MAX_DIGITS-1:0] m;
    logic                  run;
    m   = '0;
    run = 1'b1;
    for (int unsigned i = MAX_DIGITS - 1; i >= 1; i--) begin
      if (i < n) begin
        if (v[4*i +: 4] != 4'h0) begin
          run = 1'b0;
        end
        m[i] = run;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/bin_7seg.sv
// bin_7seg: combinational hex-to-7-segment decoder, active-low outputs.
//   i_bin   [3:0]  hex nibble
//   o_seg_c [6:0]  {g,f,e,d,c,b,a}, 0 = segment lit
module bin_7seg (
  input  logic [3:0] i_bin,
  output logic [6:0] o_seg_c
);

  always_comb begin
    o_seg_c = 7'h7F;
    case (i_bin)
      4'h0: o_seg_c = 7'h40;
      4'h1: o_seg_c = 7'h79;
      4'h2: o_seg_c = 7'h24;
      4'h3: o_seg_c = 7'h30;
      4'h4: o_seg_c = 7'h19;
      4'h5: o_seg_c = 7'h12;
      4'h6: o_seg_c = 7'h02;
      4'h7: o_seg_c = 7'h78;
      4'h8: o_seg_c = 7'h00;
      4'h9: o_seg_c = 7'h10;
      4'hA: o_seg_c = 7'h08;
      4'hB: o_seg_c = 7'h03;
      4'hC: o_seg_c = 7'h46;
      4'hD: o_seg_c = 7'h21;
      4'hE: o_seg_c = 7'h06;
      4'hF: o_seg_c = 7'h0E;
      default: o_seg_c = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-anode
// multi-digit 7-segment display sharing one bin_7seg decoder.
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   value       hex digits, digit 0 = value[3:0] (rightmost)
//   load        capture value into the shadow register
//   lzb_en      leading-zero blanking enable
//   seg         {g,f,e,d,c,b,a}, active-low, registered
//   an          digit enables, active-low, registered
//   frame_done  one-cycle pulse on the last drive cycle of the last digit
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SLOT_CYCLES  = 50000,
  parameter int unsigned GUARD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    lzb_en,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned DATA_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W  = $clog2(SLOT_CYCLES);
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [IDX_W-1:0] DIG_LAST   = IDX_W'(NUM_DIGITS - 1);

  // State and datapath registers
  state_t                r_state;
  logic [CNT_W-1:0]      r_slot_cnt;
  logic [IDX_W-1:0]      r_dig_idx;
  logic [DATA_W-1:0]     r_shadow;
  logic [DATA_W-1:0]     r_active;
  logic [3:0]            r_nib;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_frame_done;

  // Next-state values
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [IDX_W-1:0]      w_dig_nxt;
  logic [DATA_W-1:0]     w_shadow_nxt;
  logic [DATA_W-1:0]     w_active_nxt;
  logic [3:0]            w_nib_nxt;
  logic [6:0]            w_seg_nxt;
  logic [NUM_DIGITS-1:0] w_an_nxt;
  logic                  w_frame_nxt;

  logic [6:0]            w_dec;
  logic [MAX_DIGITS-1:0] w_lz_mask;
  logic                  w_blank;

  // Single shared decoder, fed from the registered nibble
  bin_7seg u_dec (
    .i_bin   (r_nib),
    .o_seg_c (w_dec)
  );

  // Blanking mask is taken from the displayed (active) copy
  assign w_lz_mask = lz_mask(LZ_W'(r_active), NUM_DIGITS);
  assign w_blank   = lzb_en & w_lz_mask[MASK_IDX_W'(r_dig_idx)];

  // State register and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= GUARD;
      r_slot_cnt   <= '0;
      r_dig_idx    <= '0;
      r_shadow     <= '0;
      r_active     <= '0;
      r_nib        <= '0;
      r_seg        <= SEG_BLANK;
      r_an         <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_slot_cnt   <= w_cnt_nxt;
      r_dig_idx    <= w_dig_nxt;
      r_shadow     <= w_shadow_nxt;
      r_active     <= w_active_nxt;
      r_nib        <= w_nib_nxt;
      r_seg        <= w_seg_nxt;
      r_an         <= w_an_nxt;
      r_frame_done <= w_frame_nxt;
    end
  end

  // Next-state and next-output logic. Outputs are computed from the next
  // state so that an/seg/frame_done line up with the cycle they describe.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_slot_cnt + CNT_W'(1);
    w_dig_nxt    = r_dig_idx;
    w_shadow_nxt = load ? value : r_shadow;
    w_active_nxt = r_active;
    w_an_nxt     = '1;
    w_seg_nxt    = SEG_BLANK;
    w_frame_nxt  = 1'b0;

    case (r_state)
      GUARD: begin
        if (r_slot_cnt == GUARD_LAST) begin
          w_state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (r_slot_cnt == SLOT_LAST) begin
          w_state_nxt = GUARD;
          w_cnt_nxt   = '0;
          if (r_dig_idx == DIG_LAST) begin
            // Frame boundary: active takes the pre-load shadow value
            w_dig_nxt    = '0;
            w_active_nxt = r_shadow;
          end else begin
            w_dig_nxt = r_dig_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = GUARD;
        w_cnt_nxt   = '0;
      end
    endcase

    // r_nib always tracks the nibble of the current digit of the active copy
    w_nib_nxt = w_active_nxt[{w_dig_nxt, 2'b00} +: 4];

    // Digit and active value only change when entering GUARD, so whenever
    // the next state is DRIVE the current r_nib and mask already apply.
    if (w_state_nxt == DRIVE) begin
      w_an_nxt[w_dig_nxt] = 1'b0;
      if (!w_blank) begin
        w_seg_nxt = w_dec;
      end
      if ((w_cnt_nxt == SLOT_LAST) && (w_dig_nxt == DIG_LAST)) begin
        w_frame_nxt = 1'b1;
      end
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: self-checking bench for seg_scan_ctrl with a cycle model
// feeding an expected-output queue (NUM_DIGITS=4, SLOT=8, GUARD=2).
module tb_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int SC    = 8;
  localparam int GC    = 2;
  localparam int FRAME = ND * SC;

  logic        clk;
  logic        reset_n;
  logic [15:0] value;
  logic        load;
  logic        lzb_en;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fd;
  } exp_t;

  exp_t        sb[$];
  int          n_checks;
  int          n_fail;
  int          m_c;
  logic [15:0] m_shadow;
  logic [15:0] m_active;

  seg_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .SLOT_CYCLES  (SC),
    .GUARD_CYCLES (GC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .value      (value),
    .load       (load),
    .lzb_en     (lzb_en),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d, t=%0t)", tag, got, exp, m_c, $time);
    end
  endtask

  function automatic logic [6:0] dec7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Expected outputs in scan cycle c, from the slot position and the
  // highest nonzero digit of the displayed value.
  function automatic exp_t model_out(input int c, input logic [15:0] act, input logic lz);
    exp_t e;
    int   pos;
    int   d;
    int   hi;
    pos   = c % SC;
    d     = (c / SC) % ND;
    e.an  = 4'hF;
    e.seg = 7'h7F;
    e.fd  = (pos == SC - 1) && (d == ND - 1);
    if (pos >= GC) begin
      e.an[d] = 1'b0;
      hi = 0;
      for (int k = 0; k < ND; k++) begin
        if (act[4*k +: 4] != 4'h0) hi = k;
      end
      if (!(lz && (d > hi))) e.seg = dec7(act[4*d +: 4]);
    end
    return e;
  endfunction

  // Called at a falling edge: compare this cycle, drive inputs, predict next.
  task automatic step(input logic ld, input logic [15:0] val, input logic lz);
    exp_t e;
    logic fd_now;
    check_eq("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("an", 32'(an), 32'(e.an));
      check_eq("seg", 32'(seg), 32'(e.seg));
      check_eq("frame_done", 32'(frame_done), 32'(e.fd));
      check_eq("an_single_low", 32'($countones(~an) <= 1), 32'd1);
    end
    load   = ld;
    value  = val;
    lzb_en = lz;
    fd_now = ((m_c % SC) == SC - 1) && (((m_c / SC) % ND) == ND - 1);
    if (fd_now) m_active = m_shadow;
    if (ld) m_shadow = val;
    m_c++;
    sb.push_back(model_out(m_c, m_active, lz));
    @(negedge clk);
  endtask

  task automatic run_to(input int phase, input logic lz);
    for (int i = 0; i < FRAME; i++) begin
      if ((m_c % FRAME) == phase) break;
      step(1'b0, 16'h0000, lz);
    end
  endtask

  // Release at a falling edge and restart the model in GUARD of digit 0
  task automatic release_reset();
    reset_n  = 1'b1;
    m_c      = 0;
    m_shadow = 16'h0000;
    m_active = 16'h0000;
    sb.delete();
    sb.push_back(model_out(0, 16'h0000, lzb_en));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_c      = 0;
    m_shadow = 16'h0000;
    m_active = 16'h0000;
    reset_n  = 1'b0;
    load     = 1'b0;
    value    = 16'h0000;
    lzb_en   = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst_an", 32'(an), 32'h0000000F);
    check_eq("rst_seg", 32'(seg), 32'h0000007F);
    check_eq("rst_frame_done", 32'(frame_done), 32'd0);

    release_reset();
    repeat (40) step(1'b0, 16'h0000, 1'b0);

    // Load 1234 mid-frame, then ABCD on the frame_done cycle
    run_to(10, 1'b0);
    step(1'b1, 16'h1234, 1'b0);
    run_to(31, 1'b0);
    step(1'b1, 16'hABCD, 1'b0);
    repeat (2 * FRAME + 2) step(1'b0, 16'h0000, 1'b0);

    // Leading-zero blanking on 0050, with a mid-drive toggle of lzb_en
    step(1'b1, 16'h0050, 1'b1);
    run_to(0, 1'b1);
    repeat (FRAME) step(1'b0, 16'h0000, 1'b1);
    run_to(26, 1'b1);
    repeat (3) step(1'b0, 16'h0000, 1'b0);
    repeat (FRAME) step(1'b0, 16'h0000, 1'b1);

    // All-zero value with blanking: only digit 0 lit
    step(1'b1, 16'h0000, 1'b1);
    run_to(0, 1'b1);
    repeat (FRAME) step(1'b0, 16'h0000, 1'b1);

    // Reset pulse in the DRIVE phase of digit 2
    step(1'b1, 16'h1234, 1'b0);
    run_to(0, 1'b0);
    run_to(20, 1'b0);
    check_eq("pre_rst_an", 32'(an), 32'h0000000B);
    check_eq("pre_rst_seg", 32'(seg), 32'h00000024);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_an", 32'(an), 32'h0000000F);
    check_eq("async_rst_seg", 32'(seg), 32'h0000007F);
    check_eq("async_rst_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check_eq("held_rst_an", 32'(an), 32'h0000000F);
    release_reset();
    repeat (3 * FRAME + 4) step(1'b0, 16'h0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
